// File: rtl/match_arb_pkg.sv
// rtl/match_arb_pkg.sv - shared types and constants for the match request arbiter
package match_arb_pkg;

    localparam int REQ_A_W = 3;
    localparam int REQ_C_W = 2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic [REQ_A_W-1:0] a;
        logic               b;
        logic [REQ_C_W-1:0] c;
    } req_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, purely combinational
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_valid_o = |valid_i;
        gnt_id_o    = 1'b0;
        case (valid_i)
            2'b01:   gnt_id_o = 1'b0;
            2'b10:   gnt_id_o = 1'b1;
            2'b11:   gnt_id_o = ~last_grant_i;
            default: gnt_id_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/match_req_arbiter.sv
// rtl/match_req_arbiter.sv - two requesters sharing one registered match unit
module match_req_arbiter
    import match_arb_pkg::*;
#(
    parameter int             A_W     = REQ_A_W,
    parameter int             C_W     = REQ_C_W,
    parameter logic [A_W-1:0] MATCH_A = A_W'(2),
    parameter logic [C_W-1:0] MATCH_C = C_W'(0),
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [A_W-1:0]   req0_a,
    input  logic             req0_b,
    input  logic [C_W-1:0]   req0_c,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [A_W-1:0]   req1_a,
    input  logic             req1_b,
    input  logic [C_W-1:0]   req1_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_hit,
    output logic [CNT_W-1:0] hit_count0,
    output logic [CNT_W-1:0] hit_count1
);

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_hit_q, rsp_hit_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic free, gnt_valid, gnt_id, accept;
    logic match0, match1, hit;

    rr_arb2 u_arb (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_id_o     (gnt_id)
    );

    // The slot frees up in the same cycle the consumer takes the held response.
    assign free       = (state_q == IDLE) || rsp_ready;
    assign accept     = free && gnt_valid;
    assign req0_ready = accept && (gnt_id == PORT0);
    assign req1_ready = accept && (gnt_id == PORT1);

    assign match0 = (req0_a == MATCH_A) && req0_b  && (req0_c == MATCH_C);
    assign match1 = (req1_a == MATCH_A) && !req1_b && (req1_c == MATCH_C);
    assign hit    = (gnt_id == PORT1) ? match1 : match0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_hit_d    = rsp_hit_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (accept) begin
            state_d      = HOLD;
            last_grant_d = gnt_id;
            rsp_id_d     = gnt_id;
            rsp_hit_d    = hit;
            if (hit && (gnt_id == PORT0) && (cnt0_q != {CNT_W{1'b1}}))
                cnt0_d = cnt0_q + CNT_W'(1);
            if (hit && (gnt_id == PORT1) && (cnt1_q != {CNT_W{1'b1}}))
                cnt1_d = cnt1_q + CNT_W'(1);
        end else if ((state_q == HOLD) && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT1;
            rsp_id_q     <= 1'b0;
            rsp_hit_q    <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_hit_q    <= rsp_hit_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign rsp_valid  = (state_q == HOLD);
    assign rsp_id     = rsp_id_q;
    assign rsp_hit    = rsp_hit_q;
    assign hit_count0 = cnt0_q;
    assign hit_count1 = cnt1_q;

endmodule

// File: tb/tb_match_req_arbiter.sv
// tb/tb_match_req_arbiter.sv - directed vector bench for match_req_arbiter
module tb_match_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rsp_ready;
    logic       req0_valid, req0_b, req1_valid, req1_b;
    logic [2:0] req0_a, req1_a;
    logic [1:0] req0_c, req1_c;

    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_hit;
    logic [7:0] hit_count0, hit_count1;
    logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_hit;
    logic [1:0] s_hit_count0, s_hit_count1;

    match_req_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_hit(rsp_hit),
        .hit_count0(hit_count0), .hit_count1(hit_count1)
    );

    match_req_arbiter #(.CNT_W(2)) sat (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(s_rsp_id), .rsp_hit(s_rsp_hit),
        .hit_count0(s_hit_count0), .hit_count1(s_hit_count1)
    );

    typedef struct {
        logic       rst;
        logic       v0;
        logic [2:0] a0;
        logic       b0;
        logic [1:0] c0;
        logic       v1;
        logic [2:0] a1;
        logic       b1;
        logic [1:0] c1;
        logic       rr;
        logic       er0;
        logic       er1;
        logic       ev;
        logic       eid;
        logic       ehit;
        int         ec0;
        int         ec1;
    } vec_t;

    vec_t tbl[20];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic apply(input string tag, input vec_t v);
        rst = v.rst; rsp_ready = v.rr;
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_c = v.c0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_c = v.c1;
        #2;
        chk({tag, "_req0_ready"}, 32'(req0_ready), 32'(v.er0));
        chk({tag, "_req1_ready"}, 32'(req1_ready), 32'(v.er1));
        chk({tag, "_sat_readies"}, {30'd0, s_req1_ready, s_req0_ready}, {30'd0, v.er1, v.er0});
        @(posedge clk);
        #1;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(v.ev));
        chk({tag, "_sat_rsp_valid"}, 32'(s_rsp_valid), 32'(v.ev));
        if (v.ev) begin
            chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(v.eid));
            chk({tag, "_rsp_hit"}, 32'(rsp_hit), 32'(v.ehit));
        end
        chk({tag, "_hit_count0"}, 32'(hit_count0), 32'(v.ec0));
        chk({tag, "_hit_count1"}, 32'(hit_count1), 32'(v.ec1));
        chk({tag, "_sat_hit_count0"}, 32'(s_hit_count0), 32'(sat3(v.ec0)));
        chk({tag, "_sat_hit_count1"}, 32'(s_hit_count1), 32'(sat3(v.ec1)));
    endtask

    initial begin
        //          rst v0 a0 b0 c0 v1 a1 b1 c1 rr  r0 r1 ev id hit c0 c1
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0};
        tbl[1]  = '{0, 1, 2, 1, 0, 0, 0, 0, 0, 1,  1, 0, 1, 0, 1,  1, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 1,  0, 1, 1, 1, 1,  1, 1};
        tbl[3]  = '{0, 0, 0, 0, 0, 1, 2, 1, 0, 1,  0, 1, 1, 1, 0,  1, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  1, 1};
        tbl[5]  = '{0, 1, 2, 1, 0, 1, 3, 0, 0, 1,  1, 0, 1, 0, 1,  2, 1};
        tbl[6]  = '{0, 1, 2, 1, 0, 1, 3, 0, 0, 1,  0, 1, 1, 1, 0,  2, 1};
        tbl[7]  = '{0, 1, 2, 1, 0, 1, 3, 0, 0, 1,  1, 0, 1, 0, 1,  3, 1};
        tbl[8]  = '{0, 1, 2, 1, 0, 1, 3, 0, 0, 1,  0, 1, 1, 1, 0,  3, 1};
        tbl[9]  = '{0, 1, 2, 1, 1, 0, 0, 0, 0, 1,  1, 0, 1, 0, 0,  3, 1};
        tbl[10] = '{0, 1, 2, 1, 1, 1, 2, 0, 0, 0,  0, 0, 1, 0, 0,  3, 1};
        tbl[11] = '{0, 1, 2, 1, 1, 1, 2, 0, 0, 0,  0, 0, 1, 0, 0,  3, 1};
        tbl[12] = '{0, 1, 2, 1, 1, 1, 2, 0, 0, 0,  0, 0, 1, 0, 0,  3, 1};
        tbl[13] = '{0, 1, 2, 1, 1, 1, 2, 0, 0, 1,  0, 1, 1, 1, 1,  3, 2};
        tbl[14] = '{0, 1, 2, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1,  3, 2};
        tbl[15] = '{1, 1, 2, 1, 0, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0};
        tbl[16] = '{0, 1, 2, 1, 0, 1, 2, 0, 0, 1,  1, 0, 1, 0, 1,  1, 0};
        tbl[17] = '{1, 1, 2, 1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0,  0, 0};
        tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0};
        tbl[19] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1,  0, 1, 1, 1, 0,  0, 0};

        for (int i = 0; i < 20; i++)
            apply($sformatf("v%0d", i), tbl[i]);

        // Five back-to-back port-0 hits: the 2-bit counter pins at 3, the 8-bit one keeps going.
        apply("sat_rst", '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0});
        for (int k = 1; k <= 5; k++)
            apply($sformatf("sat%0d", k), '{0, 1, 2, 1, 0, 0, 0, 0, 0, 1,  1, 0, 1, 0, 1,  k, 0});
        apply("sat_drain", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  5, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_req_arbiter.md
Name: match_req_arbiter

Overview:
Shares one registered pattern-match unit between two requesters. Each requester submits an (a, b, c) tuple over a valid/ready handshake. Each requester has its own match rule:
- Port 0 hits on a==MATCH_A, b==1, c==MATCH_C.
- Port 1 hits on a==MATCH_A, b==0, c==MATCH_C.

A round-robin arbiter grants the unit to one requester. Results are returned on a single tagged response channel, and the block keeps saturating per-port hit counters.

Parameters:
A_W, 3, width of field a
C_W, 2, width of field c
MATCH_A, 2, value of a required for a hit (A_W bits)
MATCH_C, 0, value of c required for a hit (C_W bits)
CNT_W, 8, width of each hit counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 accepted this cycle when valid&ready
req0_a  in  A_W  port 0 field a
req0_b  in  1  port 0 field b
req0_c  in  C_W  port 0 field c
req1_valid / req1_ready / req1_a / req1_b / req1_c  same as port 0, for port 1
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  1  port whose request produced this response
rsp_hit  out  1  match result for that request
hit_count0  out  CNT_W  saturating count of port 0 hits
hit_count1  out  CNT_W  saturating count of port 1 hits

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_hit=0.
  - hit_count0=0, hit_count1=0.
  - State = IDLE.
  - Round-robin pointer last_grant=1, so port 0 wins the first tie.
- States:
  - IDLE: no response held.
  - HOLD: rsp_valid=1, response waiting for rsp_ready.
- Slot free: free = (state==IDLE) || rsp_ready. free depends combinationally on rsp_ready; no combinational path exists from any reqN_valid to rsp_valid.
- Grant, evaluated combinationally every cycle:
  - Only req0_valid high: grant 0.
  - Only req1_valid high: grant 1.
  - Both high: grant the port != last_grant.
  - Neither high: no grant.
- Ready: reqN_ready = free && (grant==N). At most one ready is high per cycle. Ready is never asserted to a port whose valid is low.
- Accept (valid&ready on port N in cycle T), at the edge ending T:
  - rsp_valid<=1, rsp_id<=N, rsp_hit<=match_N(a,b,c).
  - last_grant<=N.
  - state<=HOLD.
  - Latency: response visible in cycle T+1.
- Match rules (pure equality compare, no arithmetic):
  - match_0 = (a==MATCH_A) && (b==1) && (c==MATCH_C).
  - match_1 = (a==MATCH_A) && (b==0) && (c==MATCH_C).
- HOLD with rsp_ready=1:
  - Response retires.
  - If an accept occurs in the same cycle, the new response loads and the state stays HOLD (back-to-back, one per cycle).
  - Otherwise rsp_valid<=0 and state<=IDLE.
- HOLD with rsp_ready=0: rsp_id and rsp_hit are held stable, and neither port is ready.
- Counters:
  - hit_countN increments by 1 at the accept edge when the accepted request from port N hits.
  - Saturates at 2^CNT_W-1 with no wrap.
- Response handshake: rsp_valid is not withdrawn until rsp_ready is seen.
- Requester protocol: requesters must hold their fields stable while valid && !ready. The block does not check this.
- Reset mid-operation: any held response is discarded with no handshake. Counters clear and the pointer returns to 1.
- A reset asserted in the same cycle as an accept takes priority. The accept is lost, and ready is still reported high in that cycle.

Decomposition:
- Shared package match_arb_pkg:
  - typedef state_t {IDLE, HOLD}.
  - typedef req_t struct {a, b, c}.
  - localparam PORT0=0, PORT1=1.
- Sub-module rr_arb2: 2-way round-robin grant from valid[1:0] and last_grant, purely combinational. It is a natural split.
- Match compare and counters stay in the top module.

Test Plan:
- Reset then req0 {a=2,b=1,c=0} with rsp_ready=1 -> req0_ready=1 in cycle 0; cycle 1 shows rsp_valid=1, rsp_id=0, rsp_hit=1; hit_count0=1.
- req1 {a=2,b=0,c=0}, then req1 {a=2,b=1,c=0} -> rsp_hit=1 then rsp_hit=0; hit_count1=1; hit_count0 unchanged.
- Both ports valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; one response per cycle; rsp_id toggles each cycle.
- Hold rsp_ready=0 for 3 cycles after an accept -> rsp_valid, rsp_id and rsp_hit stay stable and both readies stay 0. Raise rsp_ready -> a pending request is accepted in that same cycle.
- CNT_W=2, feed 5 hitting req0 requests -> hit_count0 sequence is 1,2,3,3,3.
- Assert rst while in HOLD with rsp_ready=0 -> the next cycle shows rsp_valid=0 and counters=0, and a tie grants port 0.
